mips_lsu_bus: RTL
=================

# mips_lsu_bus

Parametrised load/store unit between the multicycle MIPS core's EXEC stage and the Avalon memory-mapped bus master port. It takes one decoded memory operation at a time, computes the effective address, and generates word-aligned bus requests with correct byteenable. It honours waitrequest with an optional timeout, and returns sign/zero-extended or LWL/LWR-merged load results. It adds misalignment, illegal-op and bus-timeout detection, which the core previously lacked.

## Interface
- TIMEOUT, 255: maximum consecutive waitrequest-high cycles before abort; 0 disables the timeout.
- ADDR_W, 32: address width; base, ea and address use this width.
- clk  in  1  clock, all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request strobe, sampled only in IDLE.
- op  in  4  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR, 8 SB, 9 SH, 10 SW; any other value is illegal.
- base  in  ADDR_W  rs value.
- offset  in  16  immediate, sign-extended.
- rt_old  in  32  current rt, used for LWL/LWR merge.
- store_data  in  32  rt value for stores.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- result  out  32  load result; held until the next done.
- error  out  1  valid with done.
- err_code  out  2  0 none, 1 misaligned, 2 timeout, 3 illegal op.
- address  out  ADDR_W  Avalon address, always {ea[ADDR_W-1:2],2'b00}.
- read, write  out  1  Avalon strobes.
- waitrequest  in  1  Avalon stall.
- writedata  out  32  Avalon write data.
- byteenable  out  4  Avalon lane enables.
- readdata  in  32  Avalon read data, valid in the cycle waitrequest is low.

## Operation
- Effective address: ea = base + sext(offset), modulo 2^ADDR_W. b = ea[1:0]. Lane k = bits [8k+7:8k] (little-endian).
- All inputs are registered on accepted start. Later input changes have no effect until done.
- Validity checks, in priority order:
  - illegal op → code 3.
  - LH/LHU/SH with b[0]=1, or LW/SW with b≠0 → code 1.
  - On either error: no bus cycle; done and error asserted the next cycle; result unchanged.
- Reads (all loads) drive byteenable=4'b1111.
- Load results:
  - LB/LBU: lane b, sign-/zero-extended.
  - LH/LHU: lanes b+1:b, sign-/zero-extended.
  - LW: readdata.
- LWL merge by b:
  - 0: {rd[7:0], rt_old[23:0]}
  - 1: {rd[15:0], rt_old[15:0]}
  - 2: {rd[23:0], rt_old[7:0]}
  - 3: rd
- LWR merge by b:
  - 0: rd
  - 1: {rt_old[31:24], rd[31:8]}
  - 2: {rt_old[31:16], rd[31:16]}
  - 3: {rt_old[31:8], rd[31:24]}
- Stores:
  - SB: byteenable = 4'b0001<<b, writedata = byte replicated ×4.
  - SH: byteenable = 4'b0011<<b, writedata = halfword replicated ×2.
  - SW: byteenable = 4'b1111, writedata = store_data.
- States:
  - IDLE → CHECK on start.
  - CHECK → RESP (error) or BUS.
  - BUS holds until waitrequest is low, then → RESP.
  - BUS → RESP with code 2 when the wait counter reaches TIMEOUT.
  - RESP pulses done → IDLE.
- read/write are asserted only in BUS. address, byteenable and writedata are stable throughout BUS. The wait counter clears on entry to BUS.
- start while busy is ignored; no queueing.
- Reset values: state IDLE, busy=0, done=0, error=0, err_code=0, result=0, read=0, write=0, address=0, byteenable=0, writedata=0.

## Timing
- Start accepted at edge 0. CHECK in cycle 1. BUS (read/write high) from cycle 2. With waitrequest low in cycle 2, readdata is captured at that edge and done is high in cycle 3. Zero-wait latency is 3 cycles; each wait cycle adds 1.
- Error path: done is high in cycle 2; read/write are never asserted.
- Timeout: with waitrequest continuously high, read/write drop after exactly TIMEOUT BUS cycles. done/error/code 2 follow in the next cycle.
- waitrequest going low in the same cycle the counter reaches TIMEOUT counts as success (success wins).
- Reset mid-BUS: read/write are low from the next edge; no done is issued.
- start can be accepted in the cycle after done; back-to-back operations have one idle cycle.

## Test plan
- LB from ea=0x1003 with readdata=0x80FF_0000 → address 0x1000, result 0xFFFFFF80, done in cycle 3. LBU from the same address → 0x00000080.
- SH with base=0x2000, offset=-2 (ea=0x1FFE, b=2) and store_data=0x1234ABCD → address 0x1FFC, byteenable 4'b1100, writedata 0xABCDABCD.
- LWL with b=1, rt_old=0x11223344, readdata=0xAABBCCDD → result 0xCCDD3344. LWR with the same inputs → 0x11AABBCC.
- LW with ea=0x1002 → no read strobe, done with error=1, err_code=1. op=7 → err_code=3.
- TIMEOUT=4 with waitrequest held high → read high for exactly 4 cycles, then done with err_code=2. Second case: waitrequest low on the 4th BUS cycle → success.
- reset asserted during BUS with waitrequest high → read=0 after the next edge, busy=0, no done. A following start completes normally.

Source files
------------

// File: rtl/mips_lsu_bus.sv
// rtl/mips_lsu_bus.sv - Load/store unit bridging the MIPS EXEC stage to an Avalon-MM master port.
module mips_lsu_bus #(
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [ADDR_W-1:0] base,
  input  logic [15:0]       offset,
  input  logic [31:0]       rt_old,
  input  logic [31:0]       store_data,
  output logic              busy,
  output logic              done,
  output logic [31:0]       result,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  input  logic              waitrequest,
  output logic [31:0]       writedata,
  output logic [3:0]        byteenable,
  input  logic [31:0]       readdata
);

  typedef enum logic [1:0] {IDLE, CHECK, BUS, RESP} state_t;

  state_t            state, state_nx;
  logic [3:0]        op_r;
  logic [ADDR_W-1:0] ea_r;
  logic [31:0]       rt_r, sd_r, wait_cnt, result_r, wd_r, wd_nx, load_val, shifted;
  logic [3:0]        be_r, be_nx;
  logic [1:0]        err_r, chk_code, b;
  logic              is_load, timeout_hit;

  assign b           = ea_r[1:0];
  assign is_load     = (op_r <= 4'd6);
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == 32'(TIMEOUT - 1));
  assign shifted     = readdata >> {b, 3'b000};

  always_comb begin
    chk_code = 2'd0;
    be_nx    = 4'b1111;
    wd_nx    = sd_r;
    case (op_r)
      4'd0, 4'd1, 4'd5, 4'd6: chk_code = 2'd0;
      4'd2, 4'd3:             if (b[0]) chk_code = 2'd1;
      4'd4:                   if (b != 2'd0) chk_code = 2'd1;
      4'd8: begin
        be_nx = 4'b0001 << b;
        wd_nx = {4{sd_r[7:0]}};
      end
      4'd9: begin
        if (b[0]) chk_code = 2'd1;
        be_nx = 4'b0011 << b;
        wd_nx = {2{sd_r[15:0]}};
      end
      4'd10:                  if (b != 2'd0) chk_code = 2'd1;
      default:                chk_code = 2'd3;
    endcase
  end

  // LWL/LWR merge the unaligned word's bytes into the old rt value
  always_comb begin
    load_val = readdata;
    case (op_r)
      4'd0: load_val = {{24{shifted[7]}}, shifted[7:0]};
      4'd1: load_val = {24'd0, shifted[7:0]};
      4'd2: load_val = {{16{shifted[15]}}, shifted[15:0]};
      4'd3: load_val = {16'd0, shifted[15:0]};
      4'd5: case (b)
        2'd0:    load_val = {readdata[7:0], rt_r[23:0]};
        2'd1:    load_val = {readdata[15:0], rt_r[15:0]};
        2'd2:    load_val = {readdata[23:0], rt_r[7:0]};
        default: load_val = readdata;
      endcase
      4'd6: case (b)
        2'd0:    load_val = readdata;
        2'd1:    load_val = {rt_r[31:24], readdata[31:8]};
        2'd2:    load_val = {rt_r[31:16], readdata[31:16]};
        default: load_val = {rt_r[31:8], readdata[31:24]};
      endcase
      default: load_val = readdata;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CHECK;
      CHECK:   state_nx = (chk_code != 2'd0) ? RESP : BUS;
      BUS:     if (!waitrequest || timeout_hit) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_r     <= 4'd0;
      ea_r     <= '0;
      rt_r     <= 32'd0;
      sd_r     <= 32'd0;
      wait_cnt <= 32'd0;
      result_r <= 32'd0;
      err_r    <= 2'd0;
      address  <= '0;
      be_r     <= 4'd0;
      wd_r     <= 32'd0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_r <= op;
          ea_r <= base + {{(ADDR_W-16){offset[15]}}, offset};
          rt_r <= rt_old;
          sd_r <= store_data;
        end
        CHECK: begin
          err_r    <= chk_code;
          wait_cnt <= 32'd0;
          if (chk_code == 2'd0) begin
            address <= {ea_r[ADDR_W-1:2], 2'b00};
            be_r    <= be_nx;
            wd_r    <= wd_nx;
          end
        end
        BUS: begin
          // a completing transfer beats a timeout landing in the same cycle
          if (!waitrequest) begin
            if (is_load) result_r <= load_val;
          end else if (timeout_hit) begin
            err_r <= 2'd2;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state != IDLE);
  assign done       = (state == RESP);
  assign error      = (err_r != 2'd0);
  assign err_code   = err_r;
  assign result     = result_r;
  assign read       = (state == BUS) && is_load;
  assign write      = (state == BUS) && !is_load;
  assign byteenable = be_r;
  assign writedata  = wd_r;

endmodule
